// File: rtl/io_bus_master.sv
// io_bus_master
//   IO bus initiator that collects hex digits from a switch peripheral using a
//   ready/valid handshake. It raises ready, waits for the valid line to change
//   level, then reads the switches. It drops ready and echoes the digit to out0.
//   Digits are shifted into a 32-bit accumulator until a terminator digit
//   (bit 4 set) arrives or MAX_DIGITS digits have been taken. The total is
//   written to out1.
//
//   Peripheral map: 0x00 out0 (W), 0x04 ready (W, bit0), 0x08 out1 (W),
//                   0x0c switches (R, bits 4:0), 0x10 valid (R, bit0)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   start    one-cycle request to begin a transaction (honoured in IDLE only)
//   busy     transaction in progress (SAMPLE..DONE)
//   done     one-cycle completion pulse
//   err      sticky poll-timeout flag, cleared by the next accepted start
//   result   accumulated value of the last completed transaction
//   io_addr  bus address
//   io_dout  bus write data
//   io_we    bus write strobe, one cycle per write
//   io_din   bus read data, combinational from io_addr
module io_bus_master #(
    parameter int          MAX_DIGITS   = 8,
    parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din
);

    localparam logic [7:0] A_OUT0  = 8'h00;
    localparam logic [7:0] A_READY = 8'h04;
    localparam logic [7:0] A_OUT1  = 8'h08;
    localparam logic [7:0] A_SW    = 8'h0c;
    localparam logic [7:0] A_VALID = 8'h10;
    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [3:0] {
        S_IDLE, S_SAMPLE, S_RDY_SET, S_POLL, S_READ,
        S_RDY_CLR, S_ECHO, S_ACC_OUT, S_DONE
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic [4:0]  digit;
    logic [15:0] timer;
    logic        vref;
    logic        abort;

    logic [31:0] acc_shift;
    logic [3:0]  cnt_inc;
    logic        poll_expire;

    always_comb begin
        acc_shift   = {acc[27:0], digit[3:0]};
        cnt_inc     = cnt + 4'd1;
        poll_expire = (POLL_TIMEOUT != 16'd0) && (timer == POLL_TIMEOUT - 16'd1);
    end

    // Bus outputs are registered: each transition loads the address/data/strobe
    // that belong to the state being entered, so they are valid for that state's
    // whole cycle and io_din can be sampled at its end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= 32'd0;
            io_addr <= 8'd0;
            io_dout <= 32'd0;
            io_we   <= 1'b0;
            acc     <= 32'd0;
            cnt     <= 4'd0;
            digit   <= 5'd0;
            timer   <= 16'd0;
            vref    <= 1'b0;
            abort   <= 1'b0;
        end else begin
            io_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_SAMPLE;
                        busy    <= 1'b1;
                        acc     <= 32'd0;
                        cnt     <= 4'd0;
                        err     <= 1'b0;
                        timer   <= 16'd0;
                        abort   <= 1'b0;
                        io_addr <= A_VALID;
                        io_dout <= 32'd0;
                    end
                end
                S_SAMPLE: begin
                    // Reference level for change detection on the valid line
                    vref    <= io_din[0];
                    state   <= S_RDY_SET;
                    io_addr <= A_READY;
                    io_dout <= 32'd1;
                    io_we   <= 1'b1;
                end
                S_RDY_SET: begin
                    timer   <= 16'd0;
                    state   <= S_POLL;
                    io_addr <= A_VALID;
                    io_dout <= 32'd0;
                end
                S_POLL: begin
                    // Any level change counts, so a toggling valid works on both edges
                    if (io_din[0] != vref) begin
                        vref    <= io_din[0];
                        state   <= S_READ;
                        io_addr <= A_SW;
                    end else begin
                        timer <= timer + 16'd1;
                        if (poll_expire) begin
                            err     <= 1'b1;
                            abort   <= 1'b1;
                            state   <= S_RDY_CLR;
                            io_addr <= A_READY;
                            io_dout <= 32'd0;
                            io_we   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    digit   <= io_din[4:0];
                    state   <= S_RDY_CLR;
                    io_addr <= A_READY;
                    io_dout <= 32'd0;
                    io_we   <= 1'b1;
                end
                S_RDY_CLR: begin
                    io_we <= 1'b1;
                    if (abort) begin
                        state   <= S_ACC_OUT;
                        io_addr <= A_OUT1;
                        io_dout <= acc;
                    end else begin
                        state   <= S_ECHO;
                        io_addr <= A_OUT0;
                        io_dout <= {27'd0, digit};
                    end
                end
                S_ECHO: begin
                    // A terminator only ends the transaction; its low bits are dropped
                    if (!digit[4]) begin
                        acc <= acc_shift;
                        cnt <= cnt_inc;
                    end
                    io_we <= 1'b1;
                    if (digit[4] || cnt_inc == MAX_CNT) begin
                        state   <= S_ACC_OUT;
                        io_addr <= A_OUT1;
                        io_dout <= digit[4] ? acc : acc_shift;
                    end else begin
                        state   <= S_RDY_SET;
                        io_addr <= A_READY;
                        io_dout <= 32'd1;
                    end
                end
                S_ACC_OUT: begin
                    result  <= acc;
                    state   <= S_DONE;
                    done    <= 1'b1;
                    io_addr <= 8'd0;
                    io_dout <= 32'd0;
                end
                S_DONE: begin
                    // start seen here is deliberately dropped
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    io_addr <= 8'd0;
                    io_dout <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter MAX_DIGITS, default 8, maximum hex digits accumulated per transaction (range 1..8).
REQ-002 Parameter POLL_TIMEOUT, default 16'hFFFF, number of POLL cycles before abort; 0 disables the timeout.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a transaction.
REQ-006 busy  output  1  high from the cycle after accepted start until DONE is left.
REQ-007 done  output  1  one-cycle pulse when a transaction completes.
REQ-008 err  output  1  sticky timeout flag; cleared on accepted start.
REQ-009 result  output  32  accumulated value of the last completed transaction.
REQ-010 io_addr  output  8  IO bus address.
REQ-011 io_dout  output  32  IO bus write data.
REQ-012 io_we  output  1  IO bus write strobe; one clk per write.
REQ-013 io_din  input  32  IO bus read data, combinational from io_addr in the same cycle.

Function
REQ-014 Block SHALL be IO bus initiator for the peripheral map: 0x00 out0 (W), 0x04 ready (W, bit0), 0x08 out1 (W), 0x0c switches (R, bits 4:0), 0x10 valid (R, bit0).
REQ-015 FSM states SHALL be IDLE, SAMPLE, RDY_SET, POLL, READ, RDY_CLR, ECHO, ACC_OUT, DONE; each non-POLL state lasts exactly one cycle.
REQ-016 IDLE: io_addr=0, io_dout=0, io_we=0; start=1 -> SAMPLE, acc<=0, cnt<=0, err<=0, timer<=0.
REQ-017 SAMPLE: io_addr=0x10, read only; vref<=io_din[0]; -> RDY_SET.
REQ-018 RDY_SET: write addr 0x04, data 1; timer<=0; -> POLL.
REQ-019 POLL: io_addr=0x10, read only. If io_din[0]!=vref: vref<=io_din[0], -> READ. Else timer increments; if POLL_TIMEOUT!=0 and timer==POLL_TIMEOUT-1: err<=1, -> RDY_CLR with abort flag set.
REQ-020 READ: io_addr=0x0c; digit<=io_din[4:0]; -> RDY_CLR.
REQ-021 RDY_CLR: write addr 0x04, data 0; -> ACC_OUT if abort, else ECHO.
REQ-022 ECHO: write addr 0x00, data {27'b0,digit}. If digit[4]=0: acc<={acc[27:0],digit[3:0]}, cnt<=cnt+1. Next state: ACC_OUT if digit[4]=1 or cnt+1==MAX_DIGITS; else RDY_SET.
REQ-023 digit[4]=1 SHALL be a terminator only; its low bits SHALL NOT enter acc.
REQ-024 ACC_OUT: write addr 0x08, data acc; result<=acc; -> DONE.
REQ-025 DONE: done=1 for this cycle; bus idle; -> IDLE.
REQ-026 start SHALL be ignored outside IDLE; start in DONE is lost.
REQ-027 Latency with an immediate valid toggle: 5 cycles per digit (RDY_SET..ECHO); start-to-done = 1+5*N+2+1 cycles for N digits, including the terminator digit.
REQ-028 Valid detection SHALL be on either edge (level change against vref), matching toggle-style valid.
REQ-029 acc SHALL be 32 bits, left-shift 4 per digit; with MAX_DIGITS=8, no overflow possible.
REQ-030 io_we SHALL never be high in IDLE, SAMPLE, POLL, READ or DONE.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, io_we=0, io_addr=0, io_dout=0, busy=0, done=0, err=0, result=0, acc=0, cnt=0, vref=0, timer=0.
REQ-032 Reset asserted mid-transaction SHALL abort with no further bus writes; after release the block waits for start.

Verification
REQ-033 Reset, then start; valid toggles once with in=5'h0A, then once with in=5'h10 -> writes 0x04<-1, 0x04<-0, 0x00<-0x0A, 0x04<-1, 0x04<-0, 0x00<-0x10, 0x08<-0x0000000A; result=0x0000000A; done pulse; err=0.
REQ-034 Eight digits 1..8 with no terminator (MAX_DIGITS=8) -> auto-finish after the 8th ECHO; 0x08<-0x12345678; result=0x12345678.
REQ-035 POLL_TIMEOUT=4, valid never changes -> 4 POLL cycles, then 0x04<-0, 0x08<-acc(0); err=1; done pulse; err clears on the next start.
REQ-036 Pulse start while busy and in DONE -> ignored; exactly one transaction; busy deasserts after DONE.
REQ-037 Assert rst during POLL -> io_we=0 in the same cycle; all outputs at reset values; after release, a new start behaves as REQ-033.
REQ-038 Valid toggles 1->0 (falling level) with in=5'h03 -> detected as a change; 0x00<-0x03; digit accumulated.
